// File: rtl/rv_core_pkg.sv
// Shared core definitions: data width, PC step, fetch FSM states.
// Used by instr_fetch_buffer and fetch_fifo.
package rv_core_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] PC_INC = 32'd4;

   typedef enum logic {
      FETCH = 1'b0,
      FLUSH = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
      return a & ~(PC_INC - 32'd1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch buffer: DEPTH x 64-bit ring with count-based full/empty.
// Push at full is accepted only together with a pop; clear wins over all.
module fetch_fifo
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          push,
   input  logic [63:0]   push_data,
   input  logic          pop,
   output logic [63:0]   head,
   output logic [CW-1:0] count,
   output logic          empty
);

   logic [63:0]   mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          full;
   logic          do_push;
   logic          do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/instr_fetch_buffer.sv
// Instruction prefetch unit: credit-limited requests into a small FIFO.
// Define IFETCH_MISALIGN_CHECK_EN to add the fetch_misaligned output.
module instr_fetch_buffer
   import rv_core_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_data,
   output logic [31:0] instr_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
   ,
   output logic        fetch_misaligned
`endif
);

   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_e    state;
   logic [XLEN-1:0] fetch_pc;
   logic [1:0]      outstanding;
   logic [1:0]      out_next;
   logic [XLEN-1:0] rsp_pc [2];
   logic            rsp_wr;
   logic            rsp_rd;
   logic            drop_rsp;
   logic            blocked;
   logic [XLEN-1:0] target;

   logic            granted;
   logic            rsp;
   logic            push;
   logic            pop;
   logic [63:0]     head;
   logic [CW-1:0]   count;
   logic            empty;
   logic [CW:0]     inflight;
   logic            credit;

`ifdef IFETCH_MISALIGN_CHECK_EN
   logic misaligned;
   assign target           = redirect_pc;
   assign blocked          = misaligned;
   assign fetch_misaligned = misaligned;
`else
   assign target  = word_align(redirect_pc);
   assign blocked = 1'b0;
`endif

   // Free slots must cover every response still in flight.
   assign inflight = {1'b0, count} + (CW+1)'(outstanding);
   assign credit   = (inflight < (CW+1)'(DEPTH)) && (outstanding != 2'd2);

   assign imem_req  = !rst && (state == FETCH) && !redirect_valid
                    && !blocked && credit;
   assign imem_addr = fetch_pc;
   assign granted   = imem_req && imem_gnt;

   assign rsp  = imem_rvalid && !drop_rsp && (outstanding != 2'd0);
   assign push = rsp && !rst && (state == FETCH) && !redirect_valid;

   assign instr_valid = !rst && !empty && !redirect_valid;
   assign pop         = instr_valid && instr_ready;
   assign instr_data  = instr_valid ? head[63:32] : '0;
   assign instr_pc    = instr_valid ? head[31:0]  : '0;

   always_comb begin
      out_next = outstanding;
      if (granted && !rsp) begin
         out_next = outstanding + 2'd1;
      end else if (!granted && rsp) begin
         out_next = outstanding - 2'd1;
      end
   end

   fetch_fifo #(
      .DEPTH(DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clear     (redirect_valid),
      .push      (push),
      .push_data ({imem_rdata, rsp_pc[rsp_rd]}),
      .pop       (pop),
      .head      (head),
      .count     (count),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= FETCH;
         fetch_pc    <= RESET_PC;
         outstanding <= 2'd0;
         rsp_pc[0]   <= '0;
         rsp_pc[1]   <= '0;
         rsp_wr      <= 1'b0;
         rsp_rd      <= 1'b0;
         drop_rsp    <= 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
         misaligned  <= 1'b0;
`endif
      end else begin
         drop_rsp    <= 1'b0;
         outstanding <= out_next;
         if (granted) begin
            rsp_pc[rsp_wr] <= fetch_pc;
            rsp_wr         <= ~rsp_wr;
         end
         if (rsp) begin
            rsp_rd <= ~rsp_rd;
         end
         if (redirect_valid) begin
            fetch_pc <= target;
`ifdef IFETCH_MISALIGN_CHECK_EN
            misaligned <= (redirect_pc[1:0] != 2'b00);
`endif
            if (state == FLUSH || out_next != 2'd0) begin
               state <= FLUSH;
            end else begin
               state <= FETCH;
            end
         end else begin
            if (granted) begin
               fetch_pc <= fetch_pc + PC_INC;
            end
            if (state == FLUSH && out_next == 2'd0) begin
               state <= FETCH;
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_buffer.sv
// Self-checking bench for instr_fetch_buffer: directed scenarios plus
// random traffic against an address-stream reference model.
module tb_instr_fetch_buffer;

   localparam int          DEPTH = 4;
   localparam logic [31:0] RPC   = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr_data;
   logic [31:0] instr_pc;
`ifdef IFETCH_MISALIGN_CHECK_EN
   logic        fetch_misaligned;
`endif

   instr_fetch_buffer #(
      .DEPTH    (DEPTH),
      .RESET_PC (RPC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_data     (instr_data),
      .instr_pc       (instr_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
      ,
      .fetch_misaligned (fetch_misaligned)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference state: next address to be requested, next PC to be consumed.
   logic [31:0] fetch_exp;
   logic [31:0] exp_pc;
   bit          pend_v;
   logic [31:0] pend_d;
   bit          stall_prev;
   logic [31:0] prev_addr;
   bit          mis_exp;
   bit          data_mode;
   int          pops;
   bit          obs_valid;
   bit          obs_req;
   logic [31:0] obs_addr;
   bit          obs_pop;
   logic [31:0] obs_pop_pc;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] memf(input logic [31:0] a);
      if (data_mode) return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
      return a;
   endfunction

   function automatic logic [31:0] tgt(input logic [31:0] a);
`ifdef IFETCH_MISALIGN_CHECK_EN
      return a;
`else
      return a & 32'hFFFF_FFFC;
`endif
   endfunction

   task automatic cycle(input bit r, input bit g, input bit rdy,
                        input bit rd, input logic [31:0] rpc);
      @(negedge clk);
      rst            = r;
      imem_gnt       = g;
      instr_ready    = rdy;
      redirect_valid = rd;
      redirect_pc    = rpc;
      imem_rvalid    = pend_v;
      imem_rdata     = pend_d;
      #1;
      obs_valid = instr_valid;
      obs_req   = imem_req;
      obs_addr  = imem_addr;
      obs_pop   = 1'b0;
      if (r) begin
         chk("rst_req", {31'd0, imem_req}, 32'd0);
         chk("rst_valid", {31'd0, instr_valid}, 32'd0);
         chk("rst_data", instr_data, 32'd0);
         chk("rst_pc", instr_pc, 32'd0);
         fetch_exp  = RPC;
         exp_pc     = RPC;
         mis_exp    = 1'b0;
         stall_prev = 1'b0;
         pend_v     = 1'b0;
      end else begin
`ifdef IFETCH_MISALIGN_CHECK_EN
         chk("misaligned", {31'd0, fetch_misaligned}, {31'd0, mis_exp});
`endif
         if (mis_exp) chk("mis_noreq", {31'd0, imem_req}, 32'd0);
         if (rd) begin
            chk("redir_valid", {31'd0, instr_valid}, 32'd0);
            chk("redir_req", {31'd0, imem_req}, 32'd0);
         end
         if (stall_prev && imem_req) chk("addr_hold", imem_addr, prev_addr);
         if (imem_req && imem_gnt) chk("req_addr", imem_addr, fetch_exp);
         if (instr_valid && instr_ready) begin
            chk("pop_pc", instr_pc, exp_pc);
            chk("pop_data", instr_data, memf(exp_pc));
            obs_pop    = 1'b1;
            obs_pop_pc = instr_pc;
            exp_pc     = exp_pc + 32'd4;
            pops++;
         end
         pend_v     = imem_req && imem_gnt;
         pend_d     = memf(imem_addr);
         stall_prev = imem_req && !imem_gnt;
         prev_addr  = imem_addr;
         if (rd) begin
            fetch_exp  = tgt(rpc);
            exp_pc     = tgt(rpc);
            mis_exp    = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
            mis_exp    = (rpc[1:0] != 2'b00);
`endif
            stall_prev = 1'b0;
         end else if (imem_req && imem_gnt) begin
            fetch_exp = fetch_exp + 32'd4;
         end
      end
   endtask

   task automatic do_reset();
      cycle(1, 1, 1, 0, 32'd0);
      cycle(1, 1, 1, 0, 32'd0);
      // Stray response right after release must be ignored.
      pend_v = 1'b1;
      pend_d = 32'hDEAD_BEEF;
      pops   = 0;
   endtask

   task automatic first_pop_after(input string tag, input logic [31:0] want);
      bit got;
      got = 1'b0;
      for (int i = 0; i < 8; i++) begin
         cycle(0, 1, 1, 0, 32'd0);
         if (obs_pop && !got) begin
            got = 1'b1;
            chk(tag, obs_pop_pc, want);
         end
      end
      chk({tag, "_seen"}, {31'd0, got}, 32'd1);
   endtask

   initial begin
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_gnt       = 1'b0;
      imem_rvalid    = 1'b0;
      imem_rdata     = '0;
      instr_ready    = 1'b0;
      pend_v         = 1'b0;
      pend_d         = '0;
      data_mode      = 1'b0;
      fetch_exp      = RPC;
      exp_pc         = RPC;
      stall_prev     = 1'b0;
      prev_addr      = '0;
      mis_exp        = 1'b0;
      pops           = 0;

      // Reset and full-rate streaming with data equal to address.
      do_reset();
      for (int k = 0; k < 24; k++) begin
         cycle(0, 1, 1, 0, 32'd0);
         if (k == 0) begin
            chk("first_req", {31'd0, obs_req}, 32'd1);
            chk("first_addr", obs_addr, RPC);
         end
         if (k >= 2) chk("stream_valid", {31'd0, obs_valid}, 32'd1);
      end
      chk("stream_pops", pops, 32'd22);

      // Grant stall in the middle of the stream.
      for (int k = 0; k < 3; k++) cycle(0, 0, 1, 0, 32'd0);
      for (int k = 0; k < 6; k++) cycle(0, 1, 1, 0, 32'd0);

      // Redirect with responses in flight.
      cycle(0, 1, 1, 1, 32'h0000_0100);
      first_pop_after("redir_first", 32'h0000_0100);

`ifdef IFETCH_MISALIGN_CHECK_EN
      cycle(0, 1, 1, 1, 32'h0000_0102);
      for (int k = 0; k < 6; k++) cycle(0, 1, 1, 0, 32'd0);
      chk("mis_flag", {31'd0, fetch_misaligned}, 32'd1);
      chk("mis_req_low", {31'd0, obs_req}, 32'd0);
      cycle(0, 1, 1, 1, 32'h0000_0200);
      first_pop_after("mis_clear", 32'h0000_0200);
`else
      cycle(0, 1, 1, 1, 32'h0000_0102);
      first_pop_after("unaligned_first", 32'h0000_0100);
`endif

      // PC wraps past the top of the address space.
      cycle(0, 1, 1, 1, 32'hFFFF_FFF8);
      first_pop_after("wrap_first", 32'hFFFF_FFF8);
      chk("wrap_exp", exp_pc, 32'h0000_0010);

      // Backpressure: exactly DEPTH entries buffered, then drained in order.
      data_mode = 1'b1;
      do_reset();
      for (int k = 0; k < 12; k++) cycle(0, 1, 0, 0, 32'd0);
      chk("bp_req_off", {31'd0, obs_req}, 32'd0);
      chk("bp_valid", {31'd0, obs_valid}, 32'd1);
      pops = 0;
      for (int k = 0; k < 8; k++) cycle(0, 0, 1, 0, 32'd0);
      chk("bp_pops", pops, DEPTH);
      chk("bp_order", exp_pc, 32'(4 * DEPTH));

      // Random traffic, redirects and occasional resets.
      for (int k = 0; k < 1500; k++) begin
         cycle($urandom_range(0, 199) == 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 3) != 0,
               $urandom_range(0, 29) == 0,
               $urandom & 32'hFFFF_FFFC);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
